// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel Gx window sequencer.
//   pixel_t   : unsigned 8-bit pixel
//   gx_t      : 11-bit Gx result as produced by the gx window blocks
//   WIN_*     : geometry of the 3-row x 4-column window buffer
//   state_t   : sequencer FSM state encoding
//   cnt_width : width helper for counters that must hold 0..n-1
// -----------------------------------------------------------------------------
package sobel_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [10:0] gx_t;

  localparam int WIN_ROWS   = 3;
  localparam int WIN_COLS   = 4;
  localparam int WIN_BYTES  = WIN_ROWS * WIN_COLS;
  // Two columns: the part of the window that is kept or refilled per step.
  localparam int HALF_BYTES = WIN_BYTES / 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_CALC = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // At least one bit, even for a counter that only ever holds 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// -----------------------------------------------------------------------------
// sobel_pos_counter
// Tracks the window position inside the frame: window index within the current
// band and band index within the frame.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : start of frame, both counters to 0
//   win_step   : advance to the next window of the same band
//   band_step  : first window of the next band
//   last_win   : current window is the last one of its band
//   last_band  : current band is the last one of the frame
// -----------------------------------------------------------------------------
module sobel_pos_counter
  import sobel_pkg::*;
#(
  parameter int WPB    = 3,
  parameter int NBANDS = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic win_step,
  input  logic band_step,
  output logic last_win,
  output logic last_band
);

  localparam int WW = cnt_width(WPB);
  localparam int BW = cnt_width(NBANDS);

  logic [WW-1:0] win_cnt;
  logic [BW-1:0] band_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_cnt  <= '0;
      band_cnt <= '0;
    end else if (clear) begin
      win_cnt  <= '0;
      band_cnt <= '0;
    end else if (win_step) begin
      win_cnt  <= win_cnt + 1'b1;
    end else if (band_step) begin
      win_cnt  <= '0;
      band_cnt <= band_cnt + 1'b1;
    end
  end

  assign last_win  = (win_cnt  == WW'(WPB - 1));
  assign last_band = (band_cnt == BW'(NBANDS - 1));

endmodule

// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
// Assembles 3x4 pixel windows from a column-major pixel stream, runs the paired
// gx window blocks for CALC_LATENCY cycles, captures both Gx results and offers
// them downstream with a valid/ready handshake. Steps two columns per window
// and one row per band.
//   clk, n_rst              : clock, asynchronous active-low reset
//   start                   : frame start pulse (only honoured when idle)
//   pixel_in/valid/ready    : pixel stream input handshake
//   data_buffer             : window bytes, index = col*3 + row
//   enable_calc             : gx blocks compute while high
//   gx_out_1, gx_out_2      : results of windows on columns 0-2 and 1-3
//   result_1/2/valid/ready  : captured results, output handshake
//   busy                    : frame in progress
//   done                    : one-cycle pulse after the last window
// -----------------------------------------------------------------------------
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 6,
  parameter int CALC_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  pixel_t                 pixel_in,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output pixel_t [WIN_BYTES-1:0] data_buffer,
  output logic                   enable_calc,
  input  gx_t                    gx_out_1,
  input  gx_t                    gx_out_2,
  output gx_t                    result_1,
  output gx_t                    result_2,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int WPB    = (IMG_WIDTH - 2) / 2;
  localparam int NBANDS = IMG_HEIGHT - 2;
  localparam int CW     = cnt_width(CALC_LATENCY);

  state_t        state;
  logic [3:0]    fill_ptr;
  logic [CW-1:0] calc_cnt;

  logic beat;
  logic calc_last;
  logic out_hs;
  logic last_win;
  logic last_band;

  assign beat      = pixel_valid && pixel_ready;
  assign calc_last = (calc_cnt == CW'(CALC_LATENCY - 1));
  // result_valid is always set while in OUT, so ready alone completes it.
  assign out_hs    = (state == ST_OUT) && result_ready;

  sobel_pos_counter #(
    .WPB    (WPB),
    .NBANDS (NBANDS)
  ) u_pos (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     ((state == ST_IDLE) && start),
    .win_step  (out_hs && !last_win),
    .band_step (out_hs && last_win && !last_band),
    .last_win  (last_win),
    .last_band (last_band)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      fill_ptr     <= '0;
      calc_cnt     <= '0;
      // NOTE: the window buffer is a visible output with a defined reset
      // value, so it is reset like any other register rather than left as
      // an uninitialised memory.
      data_buffer  <= '0;
      result_1     <= '0;
      result_2     <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fill_ptr <= '0;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (beat) begin
            data_buffer[fill_ptr] <= pixel_in;
            fill_ptr              <= fill_ptr + 4'd1;
            if (fill_ptr == 4'(WIN_BYTES - 1)) begin
              calc_cnt <= '0;
              state    <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (calc_last) begin
            result_1     <= gx_out_1;
            result_2     <= gx_out_2;
            result_valid <= 1'b1;
            state        <= ST_OUT;
          end else begin
            calc_cnt <= calc_cnt + 1'b1;
          end
        end

        ST_OUT: begin
          if (out_hs) begin
            result_valid <= 1'b0;
            if (!last_win) begin
              // Columns 2-3 become columns 0-1; only two new columns needed.
              for (int i = 0; i < HALF_BYTES; i++) begin
                data_buffer[i] <= data_buffer[i + HALF_BYTES];
              end
              fill_ptr <= 4'(HALF_BYTES);
              state    <= ST_FILL;
            end else if (!last_band) begin
              fill_ptr <= '0;
              state    <= ST_FILL;
            end else begin
              state    <= ST_DONE;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pixel_ready = (state == ST_FILL);
  assign enable_calc = (state == ST_CALC);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_ctrl
// Directed bench for sobel_window_ctrl (8x6 frame, CALC_LATENCY = 2). The bench
// plays the part of the gx blocks: it presents the hand-computed Gx values only
// in the last CALC cycle and junk otherwise, so a capture on the wrong edge
// shows up in result_1/result_2.
// -----------------------------------------------------------------------------
module tb_sobel_window_ctrl;

  localparam int CALC_LATENCY = 2;
  localparam logic [10:0] GX_JUNK1 = 11'h2AA;
  localparam logic [10:0] GX_JUNK2 = 11'h555;

  logic             tb_clk;
  logic             n_rst;
  logic             start;
  logic [7:0]       pixel_in;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [11:0][7:0] data_buffer;
  logic             enable_calc;
  logic [10:0]      gx_out_1;
  logic [10:0]      gx_out_2;
  logic [10:0]      result_1;
  logic [10:0]      result_2;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic             done;

  sobel_window_ctrl #(
    .IMG_WIDTH    (8),
    .IMG_HEIGHT   (6),
    .CALC_LATENCY (CALC_LATENCY)
  ) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .start        (start),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .data_buffer  (data_buffer),
    .enable_calc  (enable_calc),
    .gx_out_1     (gx_out_1),
    .gx_out_2     (gx_out_2),
    .result_1     (result_1),
    .result_2     (result_2),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event counters sampled on the active edge.
  int beat_cnt = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  always @(posedge tb_clk) begin
    if (pixel_valid && pixel_ready) beat_cnt <= beat_cnt + 1;
    if (result_valid && result_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  logic [7:0] stim    [12];
  logic [7:0] exp_buf [12];

  task automatic check(input string tag, input logic [95:0] observed,
                       input logic [95:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel_ready"}, pixel_ready, 0);
    check({tag, "_enable_calc"}, enable_calc, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_results"}, {result_1, result_2}, 0);
    check({tag, "_data_buffer"}, data_buffer, 0);
  endtask

  task automatic start_frame(input string tag);
    @(negedge tb_clk);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
  endtask

  // Sends stim[0..n-1]; with gap set, pixel_valid is high every other cycle
  // and the idle cycles carry a junk pixel that must not be written.
  task automatic feed(input int n, input bit gap, input string tag);
    int  sent = 0;
    int  cyc  = 0;
    bit  ph   = 1'b0;
    while (sent < n && cyc < 100) begin
      @(negedge tb_clk);
      cyc++;
      ph          = gap ? !ph : 1'b1;
      pixel_valid = ph;
      pixel_in    = ph ? stim[sent] : 8'hA5;
      if (ph && pixel_ready) sent++;
    end
    check({tag, "_feed_accepted"}, sent, n);
    @(negedge tb_clk);
    pixel_valid = 1'b0;
  endtask

  task automatic run_window(input bit first, input bit gap, input int stall,
                            input bit last, input logic [10:0] e1,
                            input logic [10:0] e2, input string tag);
    int          b0;
    int          en;
    int          n;
    logic [95:0] ev;
    n = first ? 12 : 6;
    if (first) begin
      for (int i = 0; i < 12; i++) exp_buf[i] = stim[i];
    end else begin
      for (int i = 0; i < 6; i++) exp_buf[i] = exp_buf[i + 6];
      for (int i = 0; i < 6; i++) exp_buf[i + 6] = stim[i];
    end
    for (int i = 0; i < 12; i++) ev[i*8 +: 8] = exp_buf[i];
    gx_out_1 = GX_JUNK1;
    gx_out_2 = GX_JUNK2;
    b0 = beat_cnt;

    feed(n, gap, tag);
    check({tag, "_beats"}, beat_cnt - b0, n);
    check({tag, "_enable_rise"}, enable_calc, 1);
    check({tag, "_valid_in_calc"}, result_valid, 0);
    check({tag, "_buffer"}, data_buffer, ev);

    // Junk pixel and an early ready during CALC must both be ignored.
    en = 0;
    while (enable_calc && en < 20) begin
      en++;
      pixel_valid  = 1'b1;
      pixel_in     = 8'hEE;
      result_ready = 1'b1;
      gx_out_1     = (en == CALC_LATENCY) ? e1 : GX_JUNK1;
      gx_out_2     = (en == CALC_LATENCY) ? e2 : GX_JUNK2;
      @(negedge tb_clk);
    end
    pixel_valid  = 1'b0;
    result_ready = 1'b0;
    gx_out_1     = GX_JUNK1;
    gx_out_2     = GX_JUNK2;
    check({tag, "_enable_cycles"}, en, CALC_LATENCY);
    check({tag, "_valid_rise"}, result_valid, 1);
    check({tag, "_result_1"}, result_1, e1);
    check({tag, "_result_2"}, result_2, e2);
    check({tag, "_buffer_frozen"}, data_buffer, ev);

    for (int s = 0; s < stall; s++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'h77;
      @(negedge tb_clk);
    end
    pixel_valid = 1'b0;
    if (stall > 0) begin
      check({tag, "_stall_valid"}, result_valid, 1);
      check({tag, "_stall_results"}, {result_1, result_2}, {e1, e2});
      check({tag, "_stall_pixel_ready"}, pixel_ready, 0);
      check({tag, "_stall_beats"}, beat_cnt - b0, n);
      check({tag, "_stall_buffer"}, data_buffer, ev);
    end

    result_ready = 1'b1;
    @(negedge tb_clk);
    result_ready = 1'b0;
    check({tag, "_valid_clear"}, result_valid, 0);
    if (last) check({tag, "_done"}, done, 1);
    else      check({tag, "_refill_ready"}, pixel_ready, 1);
  endtask

  initial begin
    int h0;
    int d0;
    n_rst        = 1'b0;
    start        = 1'b0;
    pixel_in     = 8'h00;
    pixel_valid  = 1'b0;
    result_ready = 1'b0;
    gx_out_1     = GX_JUNK1;
    gx_out_2     = GX_JUNK2;

    @(negedge tb_clk);
    check_idle_outputs("reset");
    @(negedge tb_clk);
    n_rst = 1'b1;

    // Full default frame, uniform 100: 3 windows x 4 bands, every Gx is 0.
    h0 = hs_cnt;
    d0 = done_cnt;
    start_frame("f1");
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        for (int i = 0; i < 12; i++) stim[i] = 8'd100;
        run_window(w == 0, 1'b0, 0, (b == 3) && (w == 2), 11'd0, 11'd0,
                   $sformatf("f1_b%0d_w%0d", b, w));
      end
    end
    @(negedge tb_clk);
    check("f1_handshakes", hs_cnt - h0, 12);
    check("f1_done_pulses", done_cnt - d0, 1);
    check("f1_busy_end", busy, 0);
    check("f1_done_end", done, 0);

    // Second frame: directed windows.
    start_frame("f2");
    // Cols 0-1 = 100, cols 2-3 = 200: both Gx = 4*200 - 4*100 = 400.
    for (int i = 0; i < 12; i++) stim[i] = (i < 6) ? 8'd100 : 8'd200;
    run_window(1'b1, 1'b0, 5, 1'b0, 11'd400, 11'd400, "f2_w0");

    // A start pulse while busy must not restart the frame.
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;

    // New cols 1,2,3 / 4,5,6 over kept cols of 200:
    // Gx1 = 8 - 800 = -792 -> 1256, Gx2 = 20 - 800 = -780 -> 1268.
    for (int i = 0; i < 6; i++) stim[i] = 8'(i + 1);
    run_window(1'b0, 1'b0, 0, 1'b0, 11'd1256, 11'd1268, "f2_w1");

    // New cols of 50 over kept 1..6: Gx1 = 200 - 8 = 192, Gx2 = 200 - 20 = 180.
    for (int i = 0; i < 6; i++) stim[i] = 8'd50;
    run_window(1'b0, 1'b0, 0, 1'b0, 11'd192, 11'd180, "f2_w2");

    // Band 1, gapped stream 10,17,...,87: Gx1 = 236 - 68, Gx2 = 320 - 152.
    for (int i = 0; i < 12; i++) stim[i] = 8'(10 + 7 * i);
    run_window(1'b1, 1'b1, 0, 1'b0, 11'd168, 11'd168, "f2_b1_w0");

    // Reset in the middle of the next fill.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) stim[i] = 8'd9;
    feed(3, 1'b0, "f2_partial");
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("midfill_reset");
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    check("post_reset_idle", busy, 0);

    // Clean frame after reset: cols 0-1 = 0, cols 2-3 = 255 -> Gx = 1020.
    start_frame("f3");
    for (int i = 0; i < 12; i++) stim[i] = (i < 6) ? 8'd0 : 8'd255;
    run_window(1'b1, 1'b0, 0, 1'b0, 11'd1020, 11'd1020, "f3_w0");
    check("no_done_after_abort", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencer for the Sobel Gx stage. It accepts a column-major pixel stream and assembles the 12-byte, 3-row by 4-column window that the paired gx window blocks consume. It pulses `enable_calc`, captures both 11-bit Gx results and hands them downstream with a valid/ready handshake. It sits between the pixel fetch path and the gx window blocks, and steps across the image two columns at a time.

## Interface
Parameters:
- IMG_WIDTH, 8 — pixels per row; even and ≥ 4.
- IMG_HEIGHT, 6 — rows per frame; ≥ 3.
- CALC_LATENCY, 2 — cycles `enable_calc` is held high per window; ≥ 1.

Ports:
- clk  in  1  — system clock; all state is updated on its rising edge.
- n_rst  in  1  — asynchronous, active-low reset.
- start  in  1  — frame start pulse; ignored unless the FSM is in IDLE.
- pixel_in  in  8  — incoming pixel, unsigned.
- pixel_valid  in  1  — `pixel_in` is valid.
- pixel_ready  out  1  — controller can accept a pixel.
- data_buffer  out  [11:0][7:0]  — window, column-major; index = col*3 + row.
- enable_calc  out  1  — gx blocks compute while this is high.
- gx_out_1  in  11  — window-1 result (columns 0–2).
- gx_out_2  in  11  — window-2 result (columns 1–3).
- result_1, result_2  out  11  — captured Gx results.
- result_valid  out  1  — results are available.
- result_ready  in  1  — downstream accepts the results.
- busy  out  1  — high in any state other than IDLE.
- done  out  1  — one-cycle pulse after the last window of the frame.

## Operation
- Geometry:
  - WPB (windows per band) = (IMG_WIDTH−2)/2.
  - NBANDS = IMG_HEIGHT−2.
  - Bands advance one row at a time; windows advance two columns at a time.
- Pixel order:
  - Within a window, columns are sent left to right; within a column, rows top to bottom.
  - The first window of a band takes 12 pixels. Each later window takes 6 pixels (the two new columns).
- FSM states: IDLE, FILL, CALC, OUT, DONE.
- IDLE → FILL on `start`. On entry, `win_cnt`, `band_cnt` and `fill_ptr` are set to 0.
- FILL:
  - `pixel_ready` is high.
  - On each beat (`pixel_valid && pixel_ready`), `data_buffer[fill_ptr]` is written with `pixel_in` and `fill_ptr` increments.
  - The beat at `fill_ptr` = 11 moves the FSM to CALC.
- CALC:
  - `enable_calc` is high for exactly CALC_LATENCY cycles; `data_buffer` is frozen.
  - On the edge that ends the last CALC cycle, `gx_out_1` and `gx_out_2` are registered into `result_1` and `result_2`, `result_valid` is set, and the FSM moves to OUT.
- OUT:
  - `result_valid` and the results are held until `result_ready` is seen.
  - On the handshake, `result_valid` clears, then:
    - If `win_cnt` < WPB−1: `data_buffer[0..5]` ← `data_buffer[6..11]`, `fill_ptr` ← 6, `win_cnt`++, go to FILL.
    - Else, if `band_cnt` < NBANDS−1: `win_cnt` ← 0, `fill_ptr` ← 0, `band_cnt`++, go to FILL.
    - Else: go to DONE.
- DONE: `done` is high for one cycle, then the FSM returns to IDLE.
- Reset values: all outputs 0, `data_buffer` all zero, state IDLE, all counters 0.
- Boundary conditions:
  - `start` while busy is ignored.
  - `pixel_valid` outside FILL is ignored and nothing is written.
  - `result_ready` without `result_valid` has no effect.
  - Assertion of `n_rst` in any state aborts the frame immediately. No `done` is produced, and the next frame needs a fresh `start`.
  - `data_buffer` bytes are not cleared between bands; every byte is overwritten before the next CALC.

## Timing
- Window latency = fill beats + CALC_LATENCY + 1 OUT cycle minimum. A full 12-pixel window with no stalls: last pixel at edge N, `enable_calc` high for cycles N+1 to N+CALC_LATENCY, `result_valid` high from edge N+CALC_LATENCY.
- Zero-bubble FILL: a beat is accepted every cycle while `pixel_valid` is high.
- The shift and the return to FILL happen on the same edge as the output handshake, so `pixel_ready` is high in the next cycle.
- The gx blocks must register their outputs within CALC_LATENCY enabled edges.

## Structure
- Package `sobel_pkg`:
  - typedef `pixel_t` (8 bits), typedef `gx_t` (11 bits).
  - Window size constants WIN_ROWS = 3, WIN_COLS = 4, WIN_BYTES = 12.
  - The FSM state enum.
- One sub-module, `sobel_pos_counter`, holds `win_cnt`/`band_cnt` with wrap flags `last_win` and `last_band`. The FSM, fill pointer and buffer stay in the top level.

## Test plan
- Reset, then a default frame (8×6), `result_ready` tied high, uniform stream of 100 → 12 result handshakes, all results 0, `done` pulses once, then `busy` = 0.
- First window with columns 0–1 = 100 and columns 2–3 = 200 (bytes 0–5 = 100, 6–11 = 200) → `data_buffer` matches byte for byte; `enable_calc` is high for exactly 2 cycles; `result_valid` rises on the edge after the last CALC cycle.
- Second window of a band → bytes 0–5 equal the previous bytes 6–11; exactly 6 `pixel_ready` beats before CALC.
- `result_ready` held low for 5 cycles → results and `result_valid` stable, `pixel_ready` = 0, no new beats accepted.
- `pixel_valid` toggled every other cycle → exactly 12 writes, no dropped or duplicated pixels.
- `n_rst` asserted mid-FILL → all outputs 0 immediately, state IDLE; a `start` pulse then begins a clean frame.
